// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin arbitrated 8:1 mux:
// requester count, select width, hold-counter width, FSM state encoding
// and the one-hot to binary index helper.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  // Wide enough for the largest legal hold limit (255 -> max count 254).
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Binary index of the set bit; returns 0 for an all-zero vector.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority search. Starting at (last+1) mod N_REQ
// and wrapping upward, returns the first set request bit. When mask_en is
// high the request at mask_idx is ignored, so the current owner can be
// excluded when looking for a successor.
module rr_pick #(
  parameter int N_REQ = mux_arb_pkg::N_REQ,
  parameter int SEL_W = mux_arb_pkg::SEL_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic             mask_en,
  input  logic [SEL_W-1:0] mask_idx,
  input  logic [SEL_W-1:0] last,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] req_m;
  logic [SEL_W-1:0] cand;

  // Remove the masked requester, then scan from last+1 with wrap-around.
  always_comb begin
    req_m = req;
    if (mask_en) req_m[mask_idx] = 1'b0;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = SEL_W'((int'(last) + i) % N_REQ);
      if (!valid && req_m[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 8:1 mux. Two-state FSM (IDLE/OWN)
// with registered one-hot grant, binary select, busy flag and mux output.
// Optional owner preemption after MAX_HOLD cycles is compiled in when the
// macro MUX_ARB_TIMEOUT_EN is defined; otherwise an owner keeps the grant
// until it drops its request.
//
// Handshake: req[i] is a level request; gnt[i] is the acknowledgement and
// stays high for as long as requester i owns the mux. A requester releases
// the mux by deasserting req[i]; the grant falls (or moves on) at the next
// rising edge. No other acknowledgement is involved.
module mux_rr_arbiter #(
  parameter int N_REQ    = mux_arb_pkg::N_REQ,
  parameter int SEL_W    = mux_arb_pkg::SEL_W,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        I,
  output logic [N_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]        s,
  output logic                    busy,
  output logic                    y,
  output mux_arb_pkg::arb_state_e state_dbg
);

  import mux_arb_pkg::arb_state_e;
  import mux_arb_pkg::IDLE;
  import mux_arb_pkg::OWN;
  import mux_arb_pkg::CNT_W;
  import mux_arb_pkg::onehot_to_idx;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must lie in 2..255");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             busy_q, busy_d;
  logic             y_q, y_d;
  logic             grant_new;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;

  // While owning, the owner is masked so a preemption picks someone else.
  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req      (req),
    .mask_en  (state_q == OWN),
    .mask_idx (s_q),
    .last     (last_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_full;
  assign hold_full = (cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

  // Next-state, grant, select, busy and mux-output computation.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    grant_new = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) grant_new = 1'b1;
      end
      OWN: begin
        if (!req[s_q]) begin
          // Owner released: hand over directly, or go idle if nobody waits.
          if (pick_valid) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (hold_full && pick_valid) begin
          grant_new = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (grant_new) begin
      state_d = OWN;
      gnt_d   = N_REQ'(1) << pick_idx;
      last_d  = pick_idx;
    end

    // Select follows the grant and holds its value while idle.
    s_d    = (gnt_d != '0) ? onehot_to_idx(gnt_d) : s_q;
    busy_d = (state_d == OWN);
    // Output the input selected during the previous cycle, only while the
    // mux was and stays owned; zero whenever the arbiter is idle.
    y_d    = (busy_q && busy_d) ? I[s_q] : 1'b0;
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Hold counter: clears on every grant, saturates at MAX_HOLD-1.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_new || state_d == IDLE) begin
      cnt_d = '0;
    end else if (!hold_full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // FSM state and registered outputs; reset restarts the search at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      busy_q  <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
    end
  end

  assign gnt       = gnt_q;
  assign s         = s_q;
  assign busy      = busy_q;
  assign y         = y_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table plus hand-written
// sequences for rotation, wrap-around, asynchronous reset and hold limit.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       busy;
  logic       y;
  arb_state_e state_dbg;

  int checks;
  int failures;

  mux_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .I         (din),
    .gnt       (gnt),
    .s         (s),
    .busy      (busy),
    .y         (y),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    din   = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply inputs just after an edge, advance one edge, sample 1 ns later.
  task automatic step(input logic [7:0] r, input logic [7:0] d);
    req = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    din      = 8'h00;

    // req, din -> gnt, s, busy, y
    vecs[0]  = '{8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    vecs[2]  = '{8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{8'h06, 8'hFE, 8'h02, 3'd1, 1'b1, 1'b0};
    vecs[4]  = '{8'h06, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1};
    vecs[5]  = '{8'h04, 8'h02, 8'h04, 3'd2, 1'b1, 1'b1};
    vecs[6]  = '{8'h00, 8'hFF, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[7]  = '{8'h00, 8'hFF, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[8]  = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[9]  = '{8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
    vecs[10] = '{8'h01, 8'h80, 8'h01, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_s", 32'(s), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].req, vecs[i].din);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].s));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("vec%0d_state", i), 32'(state_dbg),
            vecs[i].busy ? 32'(OWN) : 32'(IDLE));
    end

    // Full rotation with req=FF, each owner releasing after two cycles
    do_reset();
    step(8'hFF, 8'h00);
    check("rot_first_gnt", 32'(gnt), 32'h01);
    for (int k = 0; k < 8; k++) begin
      step(8'hFF, 8'h00);
      check($sformatf("rot%0d_hold", k), 32'(gnt), 32'(8'h01 << k));
      step(8'hFF & ~(8'h01 << k), 8'h00);
      check($sformatf("rot%0d_next", k), 32'(gnt), 32'(8'h01 << ((k + 1) % 8)));
      check($sformatf("rot%0d_s", k), 32'(s), 32'((k + 1) % 8));
      check($sformatf("rot%0d_busy", k), 32'(busy), 32'd1);
    end

    // Asynchronous reset while requester 5 owns the mux
    do_reset();
    step(8'h20, 8'h20);
    check("ar_gnt", 32'(gnt), 32'h20);
    step(8'h20, 8'h20);
    check("ar_y_pre", 32'(y), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_gnt_async", 32'(gnt), 32'h00);
    check("ar_y_async", 32'(y), 32'd0);
    check("ar_busy_async", 32'(busy), 32'd0);
    check("ar_s_async", 32'(s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h20, 8'h20);
    check("ar_regrant", 32'(gnt), 32'h20);
    check("ar_regrant_s", 32'(s), 32'd5);

    // Top requester alone, release to idle, then wrap-around to 0
    do_reset();
    step(8'h80, 8'h00);
    check("wr_gnt7", 32'(gnt), 32'h80);
    step(8'h00, 8'h00);
    check("wr_idle_busy", 32'(busy), 32'd0);
    check("wr_idle_gnt", 32'(gnt), 32'h00);
    check("wr_idle_s", 32'(s), 32'd7);
    step(8'h00, 8'h00);
    check("wr_idle_s2", 32'(s), 32'd7);
    step(8'h81, 8'h00);
    check("wr_wrap_gnt", 32'(gnt), 32'h01);
    check("wr_wrap_s", 32'(s), 32'd0);

    // Hold limit with two competing requesters (0 and 3)
    do_reset();
`ifdef MUX_ARB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      step(8'h09, 8'h00);
      check($sformatf("to_own0_%0d", c), 32'(gnt), 32'h01);
    end
    for (int c = 0; c < 16; c++) begin
      step(8'h09, 8'h00);
      check($sformatf("to_own3_%0d", c), 32'(gnt), 32'h08);
    end
    step(8'h09, 8'h00);
    check("to_back0", 32'(gnt), 32'h01);
`else
    for (int c = 0; c < 100; c++) begin
      step(8'h09, 8'h00);
      check($sformatf("nt_own0_%0d", c), 32'(gnt), 32'h01);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 8: number of requesters and mux inputs; fixed at 8.
REQ-002 Parameter SEL_W, default 3: select width, equal to clog2(N_REQ).
REQ-003 Parameter MAX_HOLD, default 16: cycles an owner may hold the grant before preemption; legal range is 2..255.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port req, input, 8: req[i]=1 means requester i wants the shared mux.
REQ-007 Port I, input, 8: mux data inputs; I[i] belongs to requester i.
REQ-008 Port gnt, output, 8: one-hot grant, registered, all-zero when idle.
REQ-009 Port s, output, 3: registered select (binary index of the owner); this drives the shared 8:1 mux.
REQ-010 Port busy, output, 1: high while any grant is asserted.
REQ-011 Port y, output, 1: registered mux output, equal to I[s] of the previous cycle while busy and 0 while idle.

Function
REQ-012 The FSM SHALL have two states: IDLE (gnt=0, busy=0) and OWN (exactly one gnt bit set, busy=1).
REQ-013 In IDLE with req!=0, the block SHALL enter OWN at the next edge, granting the first set req bit searching upward from (last+1) mod 8 and wrapping.
REQ-014 Grant latency SHALL be 1 cycle: a req sampled on edge k produces gnt, s and busy valid after edge k.
REQ-015 In OWN, the owner SHALL keep the grant while req[owner]=1 and no preemption occurs.
REQ-016 When req[owner]=0 is sampled:
  - if other requests are pending, the block SHALL move directly to the next round-robin owner at that edge (no idle bubble);
  - otherwise it SHALL return to IDLE.
REQ-017 `last` SHALL update to the new owner index on every grant.
REQ-018 A hold counter SHALL clear on every new grant and increment each OWN cycle, saturating at MAX_HOLD-1.
REQ-019 Preemption (see REQ-026) SHALL grant the next round-robin requester other than the owner, and the counter SHALL clear.
REQ-020 If the owner is the only requester, it SHALL keep the grant indefinitely; the counter stays saturated.
REQ-021 Requests from non-owners SHALL never alter gnt mid-ownership except through REQ-016 or REQ-019.
REQ-022 s SHALL always equal the index of the set gnt bit, and SHALL hold its last value in IDLE.
REQ-023 gnt SHALL never have more than one bit set, including across a switch.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force state=IDLE, gnt=0, s=0, busy=0, y=0, counter=0 and last=7, so the first grant after reset searches from requester 0.
REQ-025 Reset asserted mid-ownership SHALL drop the grant asynchronously; after release, arbitration restarts from requester 0.

Configuration
REQ-026 Macro MUX_ARB_TIMEOUT_EN:
  - defined: when the counter equals MAX_HOLD-1 and any other req bit is set, the owner SHALL be preempted at the next edge;
  - undefined: the counter and preemption logic are absent, and the owner is released only through REQ-016.

Structure
REQ-027 A shared package mux_arb_pkg SHALL hold N_REQ, SEL_W, the state enum (IDLE, OWN) and the one-hot-to-index function.
REQ-028 A sub-module rr_pick SHALL implement the combinational rotating-priority search (inputs req, mask-out index and last; outputs valid and idx); the FSM, counter and output registers live in the top.

Verification
REQ-029 Reset release, then req=8'h01 at cycle 0 -> gnt=8'h01, s=0, busy=1 after edge 1; with I[0]=1, y=1 after edge 2.
REQ-030 req=8'hFF held, each owner dropping its req after 2 cycles -> owners 0,1,2,...,7,0 in order, with no idle cycle between owners.
REQ-031 MUX_ARB_TIMEOUT_EN defined, MAX_HOLD=16, req=8'h09 held -> owner 0 for 16 cycles, then owner 3 for 16 cycles, then owner 0.
REQ-032 Same stimulus with the macro undefined -> owner 0 holds indefinitely; gnt stays 8'h01 for 100 cycles.
REQ-033 Owner 5 active and rst_n pulsed low mid-cycle -> gnt=0 and y=0 immediately; after release with req=8'h20, gnt=8'h20 one edge later.
REQ-034 req=8'h80 only, last=7, owner drops req -> IDLE (busy=0, gnt=0, s stays 7); later req=8'h81 -> grant goes to 0 (wrap-around).
